// File: rtl/servo_xy_scheduler_if.sv
// Host command port of servo_xy_scheduler: valid/ready transfer of one axis target.
interface servo_xy_scheduler_if #(
    parameter int POS_W = 8
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_axis_i;
    logic [POS_W-1:0] cmd_pos_i;

    modport master (
        output cmd_valid_i,
        output cmd_axis_i,
        output cmd_pos_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_axis_i,
        input  cmd_pos_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/servo_xy_scheduler.sv
// Frame-synchronous X/Y servo position scheduler with one shared slew-step datapath.
// Optional feature macro: SERVO_SCHED_SLEW_EN (slew limiting; undefined = jump straight to target).
module servo_xy_scheduler #(
    parameter int POS_W        = 8,
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP         = 4,
    parameter int CENTER       = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    servo_xy_scheduler_if.slave  cmd,
    output logic [POS_W-1:0]     pos_x_o,
    output logic [POS_W-1:0]     pos_y_o,
    output logic                 pos_stb_o,
    output logic                 frame_tick_o,
    output logic [1:0]           at_target_o
);

    localparam int               CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_RST  = POS_W'(CENTER);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPD_X,
        ST_UPD_Y,
        ST_COMMIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic [POS_W-1:0] tgt_x_q, tgt_x_d;
    logic [POS_W-1:0] tgt_y_q, tgt_y_d;
    logic             tick_q, tick_d;
    logic             stb_q, stb_d;

    logic             cmd_fire;
    logic             frame_start;
    logic [POS_W-1:0] sel_pos;
    logic [POS_W-1:0] sel_tgt;
    logic [POS_W-1:0] step_pos;

    // Ready must read low while reset is held, so rst_n gates it directly.
    assign cmd.cmd_ready_o = rst_n && ena && (state_q == ST_IDLE);

    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;
    assign pos_stb_o    = stb_q;
    assign frame_tick_o = tick_q;
    assign at_target_o  = {pos_y_q == tgt_y_q, pos_x_q == tgt_x_q};

`ifdef SERVO_SCHED_SLEW_EN
    localparam logic [POS_W-1:0] STEP_W = POS_W'(STEP);
    logic [POS_W-1:0] dist;
`endif

    always_comb begin
        cmd_fire    = cmd.cmd_valid_i && cmd.cmd_ready_o;
        frame_start = (state_q == ST_IDLE) && ena && (cnt_q == CNT_LAST);

        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        if (cmd_fire) begin
            if (cmd.cmd_axis_i) tgt_y_d = cmd.cmd_pos_i;
            else                tgt_x_d = cmd.cmd_pos_i;
        end

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (frame_start) state_d = ST_UPD_X;
            ST_UPD_X:  state_d = ST_UPD_Y;
            ST_UPD_Y:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // One step unit shared by both axes; the state picks the operands.
        sel_pos = (state_q == ST_UPD_Y) ? pos_y_q : pos_x_q;
        sel_tgt = (state_q == ST_UPD_Y) ? tgt_y_q : tgt_x_q;
`ifdef SERVO_SCHED_SLEW_EN
        dist = (sel_tgt >= sel_pos) ? sel_tgt - sel_pos : sel_pos - sel_tgt;
        if (dist <= STEP_W)         step_pos = sel_tgt;
        else if (sel_tgt > sel_pos) step_pos = sel_pos + STEP_W;
        else                        step_pos = sel_pos - STEP_W;
`else
        step_pos = sel_tgt;
`endif

        pos_x_d = (state_q == ST_UPD_X) ? step_pos : pos_x_q;
        pos_y_d = (state_q == ST_UPD_Y) ? step_pos : pos_y_q;

        tick_d = frame_start;
        stb_d  = (state_q == ST_UPD_Y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_x_q <= POS_RST;
            pos_y_q <= POS_RST;
            tgt_x_q <= POS_RST;
            tgt_y_q <= POS_RST;
            tick_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            tick_q  <= tick_d;
            stb_q   <= stb_d;
        end
    end

endmodule

// File: tb/tb_servo_xy_scheduler.sv
// Directed self-checking bench for servo_xy_scheduler (FRAME_CYCLES=16, STEP=4, CENTER=128).
module tb_servo_xy_scheduler;

    localparam int POS_W = 8;
    localparam int FC    = 16;
`ifdef SERVO_SCHED_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena   = 1'b0;
    logic [POS_W-1:0] pos_x_o, pos_y_o;
    logic             pos_stb_o, frame_tick_o;
    logic [1:0]       at_target_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    servo_xy_scheduler_if #(.POS_W(POS_W)) cmd_if ();

    servo_xy_scheduler #(
        .POS_W        (POS_W),
        .FRAME_CYCLES (FC),
        .STEP         (4),
        .CENTER       (128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmd          (cmd_if),
        .pos_x_o      (pos_x_o),
        .pos_y_o      (pos_y_o),
        .pos_stb_o    (pos_stb_o),
        .frame_tick_o (frame_tick_o),
        .at_target_o  (at_target_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!pos_stb_o && n < 64);
        if (!pos_stb_o) check_eq({tag, "_stb_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!frame_tick_o && n < 64);
        if (!frame_tick_o) check_eq({tag, "_tick_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic axis, input logic [POS_W-1:0] pos);
        int n = 0;
        cmd_if.cmd_valid_i = 1'b1;
        cmd_if.cmd_axis_i  = axis;
        cmd_if.cmd_pos_i   = pos;
        while (!cmd_if.cmd_ready_o && n < 64) begin
            cyc();
            n++;
        end
        if (!cmd_if.cmd_ready_o) check_eq("cmd_ready_timeout", 32'd0, 32'd1);
        cyc();
        cmd_if.cmd_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        logic seen_stb, seen_tick, seen_rdy;
        logic [7:0] exp_x [4];

        cmd_if.cmd_valid_i = 1'b0;
        cmd_if.cmd_axis_i  = 1'b0;
        cmd_if.cmd_pos_i   = '0;

        // 1: reset values and first frame timing
        ena = 1'b1;
        cyc();
        cyc();
        check_eq("rst_ready", cmd_if.cmd_ready_o, 0);
        check_eq("rst_pos_x", pos_x_o, 128);
        check_eq("rst_pos_y", pos_y_o, 128);
        check_eq("rst_at", at_target_o, 3);
        check_eq("rst_stb", pos_stb_o, 0);
        check_eq("rst_tick", frame_tick_o, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", cmd_if.cmd_ready_o, 1);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!frame_tick_o && n < 64);
        check_eq("first_tick_delay", n, 16);
        check_eq("tick_ready", cmd_if.cmd_ready_o, 0);
        cyc();
        check_eq("n2_stb", pos_stb_o, 0);
        cyc();
        check_eq("n3_stb", pos_stb_o, 1);
        cyc();
        check_eq("n4_stb", pos_stb_o, 0);
        check_eq("n4_ready", cmd_if.cmd_ready_o, 1);

        // 2: X ramps toward 140
        exp_x = SLEW ? '{8'd132, 8'd136, 8'd140, 8'd140} : '{8'd140, 8'd140, 8'd140, 8'd140};
        send_cmd(1'b0, 8'd140);
        for (int i = 0; i < 4; i++) begin
            wait_stb("x140");
            check_eq("x140_pos_x", pos_x_o, exp_x[i]);
            check_eq("x140_pos_y", pos_y_o, 128);
            check_eq("x140_at", at_target_o, {30'd0, 1'b1, exp_x[i] == 8'd140});
        end

        // 3: Y down to 2, then 0 (no underflow); 253 then 255 (no overflow)
        send_cmd(1'b1, 8'd2);
        for (int i = 0; i < (SLEW ? 31 : 0); i++) wait_stb("y2");
        check_eq("y2_pre", pos_y_o, SLEW ? 4 : 128);
        wait_stb("y2");
        check_eq("y2_pos_y", pos_y_o, 2);
        send_cmd(1'b1, 8'd0);
        wait_stb("y0");
        check_eq("y0_pos_y", pos_y_o, 0);
        wait_stb("y0b");
        check_eq("y0_hold", pos_y_o, 0);
        check_eq("y0_at", at_target_o, 3);
        send_cmd(1'b1, 8'd253);
        for (int i = 0; i < (SLEW ? 63 : 0); i++) wait_stb("y253");
        check_eq("y253_pre", pos_y_o, SLEW ? 252 : 0);
        wait_stb("y253");
        check_eq("y253_pos_y", pos_y_o, 253);
        send_cmd(1'b1, 8'd255);
        wait_stb("y255");
        check_eq("y255_pos_y", pos_y_o, 255);
        wait_stb("y255b");
        check_eq("y255_hold", pos_y_o, 255);
        check_eq("y255_pos_x", pos_x_o, 140);

        // 4: command held from UPD_X is accepted only back in IDLE
        wait_tick("hold");
        cmd_if.cmd_valid_i = 1'b1;
        cmd_if.cmd_axis_i  = 1'b1;
        cmd_if.cmd_pos_i   = 8'd100;
        #1;
        check_eq("hold_n1_ready", cmd_if.cmd_ready_o, 0);
        cyc();
        check_eq("hold_n2_ready", cmd_if.cmd_ready_o, 0);
        check_eq("hold_n2_pos_x", pos_x_o, 140);
        cyc();
        check_eq("hold_n3_ready", cmd_if.cmd_ready_o, 0);
        check_eq("hold_n3_stb", pos_stb_o, 1);
        check_eq("hold_n3_pos_y", pos_y_o, 255);
        cyc();
        check_eq("hold_n4_ready", cmd_if.cmd_ready_o, 1);
        cyc();
        cmd_if.cmd_valid_i = 1'b0;
        check_eq("hold_at", at_target_o, 1);
        wait_stb("hold");
        check_eq("hold_pos_y", pos_y_o, SLEW ? 251 : 100);

        // 5: reset during UPD_Y discards the frame
        send_cmd(1'b0, 8'd132);
        wait_tick("midrst");
        cyc();
        check_eq("midrst_pos_x", pos_x_o, SLEW ? 136 : 132);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pos_x0", pos_x_o, 128);
        check_eq("midrst_pos_y0", pos_y_o, 128);
        check_eq("midrst_at", at_target_o, 3);
        check_eq("midrst_ready", cmd_if.cmd_ready_o, 0);
        seen_stb  = 1'b0;
        seen_tick = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) rst_n = 1'b1;
            cyc();
            seen_stb  = seen_stb | pos_stb_o;
            seen_tick = seen_tick | frame_tick_o;
        end
        check_eq("midrst_no_stb", seen_stb, 0);
        check_eq("midrst_no_tick", seen_tick, 0);

        // 6: ena low freezes counter and blocks commands
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        ena       = 1'b0;
        seen_tick = 1'b0;
        seen_rdy  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            seen_tick = seen_tick | frame_tick_o;
            seen_rdy  = seen_rdy | cmd_if.cmd_ready_o;
        end
        check_eq("ena0_no_tick", seen_tick, 0);
        check_eq("ena0_no_ready", seen_rdy, 0);
        ena = 1'b1;
        n   = 0;
        do begin
            cyc();
            n++;
        end while (!frame_tick_o && n < 64);
        check_eq("ena_resume_delay", n, 11);
        ena = 1'b0;
        cyc();
        cyc();
        check_eq("ena_drop_stb", pos_stb_o, 1);
        cyc();
        check_eq("ena_drop_idle_stb", pos_stb_o, 0);
        check_eq("ena_drop_ready", cmd_if.cmd_ready_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
